// File: rtl/peripheral_int_ctrl_pkg.sv
// Shared definitions for the peripheral interrupt controller:
// register map offsets, controller state encoding and default code width.
package peripheral_int_ctrl_pkg;

    localparam int unsigned DEF_INT_CODE_WIDTH = 8;

    localparam logic [7:0] ADDR_PENDING  = 8'h00;
    localparam logic [7:0] ADDR_ENABLE   = 8'h04;
    localparam logic [7:0] ADDR_TRIGGER  = 8'h08;
    localparam logic [7:0] ADDR_CLAIM    = 8'h0C;
    localparam logic [7:0] ADDR_COMPLETE = 8'h10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_CLAIMED = 2'd2
    } state_t;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder: bit i set maps to code i+1, none set gives 0.
module int_prio_enc #(
    parameter int unsigned INT_NUM = 8,
    parameter int unsigned CODE_W  = 8
) (
    input  logic [INT_NUM-1:0] i_vec,
    output logic [CODE_W-1:0]  o_code
);

    logic w_found;

    // Scan upward and keep the first set bit.
    always_comb begin
        o_code  = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < INT_NUM; i++) begin
            if (!w_found && i_vec[i]) begin
                o_code  = CODE_W'(i + 1);
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/peripheral_int_ctrl.sv
// Peripheral interrupt controller: per-source gateways (edge/level), pending
// latch, fixed-priority arbitration and a claim/complete handshake through a
// small register port. The selected code feeds the CSR block.
module peripheral_int_ctrl
    import peripheral_int_ctrl_pkg::*;
#(
    parameter int unsigned INT_NUM        = 8,
    parameter int unsigned INT_CODE_WIDTH = DEF_INT_CODE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [INT_NUM-1:0]        int_src,
    input  logic [7:0]                reg_addr,
    input  logic [31:0]               reg_wdata,
    input  logic                      reg_wen,
    input  logic                      reg_ren,
    output logic [31:0]               reg_rdata,
    output logic [INT_CODE_WIDTH-1:0] peripheral_int_code
);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [INT_NUM-1:0]        r_pending;
    logic [INT_NUM-1:0]        r_enable;
    logic [INT_NUM-1:0]        r_trigger;
    logic [INT_NUM-1:0]        r_prev;
    logic [INT_CODE_WIDTH-1:0] r_cur_code;

    logic [INT_CODE_WIDTH-1:0] w_win_code;
    logic [INT_NUM-1:0]        w_req;
    logic [INT_NUM-1:0]        w_cur_mask;
    logic [INT_NUM-1:0]        w_raw_set;
    logic [INT_NUM-1:0]        w_set;
    logic [INT_NUM-1:0]        w_claim_clr;
    logic                      w_rd;
    logic                      w_cur_en;
    logic                      w_arb;
    logic                      w_claim;
    logic                      w_unused;

    // A read colliding with a write returns 0; the write still lands.
    assign w_rd      = reg_ren & ~reg_wen;
    assign w_req     = r_pending & r_enable;
    assign w_raw_set = (r_trigger & int_src & ~r_prev) | (~r_trigger & int_src);
    assign w_cur_en  = |(w_cur_mask & r_enable);
    // The claimed source's gateway stays shut until its COMPLETE.
    assign w_set       = w_raw_set & ~((r_state == ST_CLAIMED) ? w_cur_mask : '0);
    assign w_claim_clr = w_claim ? w_cur_mask : '0;
    assign w_unused    = ^reg_wdata;

    int_prio_enc #(
        .INT_NUM (INT_NUM),
        .CODE_W  (INT_CODE_WIDTH)
    ) u_prio_enc (
        .i_vec  (w_req),
        .o_code (w_win_code)
    );

    // One-hot view of the latched winner code.
    always_comb begin
        w_cur_mask = '0;
        for (int unsigned i = 0; i < INT_NUM; i++) begin
            w_cur_mask[i] = (r_cur_code == INT_CODE_WIDTH'(i + 1));
        end
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state, claim decode and interrupt code output.
    always_comb begin
        w_state_nxt         = r_state;
        w_arb               = 1'b0;
        w_claim             = 1'b0;
        peripheral_int_code = '0;
        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_arb       = 1'b1;
                    w_state_nxt = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                // Disabling the winner withdraws the request at once; pending is kept.
                if (!w_cur_en) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    peripheral_int_code = r_cur_code;
                    if (w_rd && reg_addr == ADDR_CLAIM) begin
                        w_claim     = 1'b1;
                        w_state_nxt = ST_CLAIMED;
                    end
                end
            end
            ST_CLAIMED: begin
                if (reg_wen && reg_addr == ADDR_COMPLETE &&
                    reg_wdata[INT_CODE_WIDTH-1:0] == r_cur_code) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Gateways, pending, configuration registers, winner latch and read port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pending  <= '0;
            r_enable   <= '0;
            r_trigger  <= '0;
            r_prev     <= '0;
            r_cur_code <= '0;
            reg_rdata  <= '0;
        end else begin
            r_prev    <= int_src;
            r_pending <= (r_pending | w_set) & ~w_claim_clr;
            if (w_arb) r_cur_code <= w_win_code;
            if (reg_wen) begin
                case (reg_addr)
                    ADDR_ENABLE:  r_enable  <= reg_wdata[INT_NUM-1:0];
                    ADDR_TRIGGER: r_trigger <= reg_wdata[INT_NUM-1:0];
                    default: ;
                endcase
            end
            if (reg_ren) begin
                if (!w_rd) begin
                    reg_rdata <= '0;
                end else begin
                    case (reg_addr)
                        ADDR_PENDING: reg_rdata <= 32'(r_pending);
                        ADDR_ENABLE:  reg_rdata <= 32'(r_enable);
                        ADDR_TRIGGER: reg_rdata <= 32'(r_trigger);
                        ADDR_CLAIM:   reg_rdata <= w_claim ? 32'(r_cur_code) : '0;
                        default:      reg_rdata <= '0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_peripheral_int_ctrl.sv
// Directed bench for peripheral_int_ctrl with hand-computed expectations.
module tb_peripheral_int_ctrl;

    localparam logic [7:0] A_PEND = 8'h00;
    localparam logic [7:0] A_EN   = 8'h04;
    localparam logic [7:0] A_TRIG = 8'h08;
    localparam logic [7:0] A_CLM  = 8'h0C;
    localparam logic [7:0] A_CMP  = 8'h10;
    localparam logic [7:0] A_UNM  = 8'h20;

    logic        clk;
    logic        rst;
    logic [7:0]  int_src;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_wen;
    logic        reg_ren;
    logic [31:0] reg_rdata;
    logic [7:0]  peripheral_int_code;

    int unsigned n_pass;
    int unsigned n_fail;
    int unsigned n_total;
    logic [31:0] rv;

    peripheral_int_ctrl #(
        .INT_NUM        (8),
        .INT_CODE_WIDTH (8)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .int_src             (int_src),
        .reg_addr            (reg_addr),
        .reg_wdata           (reg_wdata),
        .reg_wen             (reg_wen),
        .reg_ren             (reg_ren),
        .reg_rdata           (reg_rdata),
        .peripheral_int_code (peripheral_int_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_wen   = 1'b1;
        step();
        reg_wen   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        reg_addr = a;
        reg_ren  = 1'b1;
        step();
        reg_ren  = 1'b0;
        d        = reg_rdata;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        n_pass = 0; n_fail = 0; n_total = 0;
        rst = 1'b0; int_src = '0; reg_addr = '0; reg_wdata = '0;
        reg_wen = 1'b0; reg_ren = 1'b0;
        step(); step();
        rst = 1'b1;
        check("rst_code", 32'(peripheral_int_code), 32'h0);
        check("rst_rdata", reg_rdata, 32'h0);
        rd(A_PEND, rv); check("rst_pending", rv, 32'h0);

        // Edge source 2
        wr(A_EN, 32'h04);
        wr(A_TRIG, 32'h04);
        int_src = 8'h04; step(); int_src = 8'h00;
        check("edge_lat1", 32'(peripheral_int_code), 32'h0);
        step();
        check("edge_lat2", 32'(peripheral_int_code), 32'h3);
        rd(A_CLM, rv);
        check("edge_claim", rv, 32'h3);
        check("edge_code_drop", 32'(peripheral_int_code), 32'h0);
        rd(A_PEND, rv); check("edge_pending", rv, 32'h0);
        wr(A_CMP, 32'h3);
        step();
        check("edge_no_retrig", 32'(peripheral_int_code), 32'h0);

        // Sources 1 and 5 simultaneously
        wr(A_EN, 32'hFF);
        wr(A_TRIG, 32'hFF);
        int_src = 8'h22; step(); int_src = 8'h00; step();
        check("prio_first", 32'(peripheral_int_code), 32'h2);
        rd(A_CLM, rv); check("prio_claim", rv, 32'h2);
        wr(A_CMP, 32'h2);
        check("prio_after_cmp", 32'(peripheral_int_code), 32'h0);
        step();
        check("prio_second", 32'(peripheral_int_code), 32'h6);
        rd(A_CLM, rv); check("prio_claim2", rv, 32'h6);
        wr(A_CMP, 32'h6);

        // Level source 0 held high
        wr(A_TRIG, 32'h00);
        wr(A_EN, 32'h01);
        int_src = 8'h01; step(); step();
        check("lvl_code", 32'(peripheral_int_code), 32'h1);
        rd(A_CLM, rv); check("lvl_claim", rv, 32'h1);
        rd(A_PEND, rv); check("lvl_pend_closed", rv, 32'h0);

        // Mismatched COMPLETE while claimed
        wr(A_CMP, 32'h4);
        check("badcmp_code", 32'(peripheral_int_code), 32'h0);
        step();
        check("badcmp_code2", 32'(peripheral_int_code), 32'h0);
        rd(A_CLM, rv); check("claim_in_claimed", rv, 32'h0);
        rd(A_PEND, rv); check("badcmp_pend", rv, 32'h0);
        wr(A_CMP, 32'h1);
        step();
        check("lvl_reassert1", 32'(peripheral_int_code), 32'h0);
        step();
        check("lvl_reassert2", 32'(peripheral_int_code), 32'h1);
        int_src = 8'h00;
        rd(A_PEND, rv); check("lvl_pend_again", rv, 32'h1);
        rd(A_CLM, rv); check("lvl_claim2", rv, 32'h1);
        wr(A_CMP, 32'h1);

        // Disable the winner while asserted
        wr(A_TRIG, 32'h04);
        wr(A_EN, 32'h04);
        int_src = 8'h04; step(); int_src = 8'h00; step();
        check("dis_code", 32'(peripheral_int_code), 32'h3);
        wr(A_EN, 32'h00);
        check("dis_drop", 32'(peripheral_int_code), 32'h0);
        rd(A_PEND, rv); check("dis_pend_kept", rv, 32'h4);
        rd(A_UNM, rv); check("unmapped_rd", rv, 32'h0);
        wr(A_EN, 32'h04);
        check("reen_idle", 32'(peripheral_int_code), 32'h0);
        step();
        check("reen_code", 32'(peripheral_int_code), 32'h3);
        rd(A_CLM, rv); check("reen_claim", rv, 32'h3);

        // Simultaneous read/write: write lands, read returns 0
        reg_addr = A_EN; reg_wdata = 32'h5A; reg_wen = 1'b1; reg_ren = 1'b1;
        step();
        reg_wen = 1'b0; reg_ren = 1'b0;
        check("rw_collide_rdata", reg_rdata, 32'h0);
        rd(A_EN, rv); check("rw_collide_en", rv, 32'h5A);

        // Reset while claimed
        rst = 1'b0; step(); rst = 1'b1;
        check("mrst_code", 32'(peripheral_int_code), 32'h0);
        check("mrst_rdata", reg_rdata, 32'h0);
        rd(A_EN, rv);   check("mrst_enable", rv, 32'h0);
        rd(A_TRIG, rv); check("mrst_trigger", rv, 32'h0);
        rd(A_PEND, rv); check("mrst_pending", rv, 32'h0);
        rd(A_CLM, rv);  check("mrst_claim", rv, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/peripheral_int_ctrl.md
# peripheral_int_ctrl

Peripheral interrupt controller that gathers up to `INT_NUM` external interrupt lines and drives `peripheral_int_code` into the CSR block (which raises `mip[11]`). It detects requests, holds pending state, and picks one winner by fixed priority. It runs a claim/complete handshake through a small memory-mapped register port, so a source cannot re-interrupt until software has serviced it. It sits directly upstream of the CSR/interrupt logic, on the peripheral bus.

## Interface
Parameters:
- `INT_NUM`, 8: number of interrupt sources (1..31).
- `INT_CODE_WIDTH`, 8: width of interrupt code; must equal the `config.v` value.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset; one clock, reset is synchronous and active-low.
- `int_src`  in  `INT_NUM`  raw source lines, synchronous to `clk`.
- `reg_addr`  in  8  byte offset of the register access.
- `reg_wdata`  in  32  write data.
- `reg_wen`  in  1  write strobe, single cycle.
- `reg_ren`  in  1  read strobe, single cycle.
- `reg_rdata`  out  32  read data, registered.
- `peripheral_int_code`  out  `INT_CODE_WIDTH`  code of the asserted request; 0 = none.

## Operation
- Code mapping: source i ↔ code i+1. Code 0 means no interrupt. Lower index has higher priority.
- Registers (offsets):
  - 0x00 PENDING: read-only, bit i = pending[i].
  - 0x04 ENABLE: read/write.
  - 0x08 TRIGGER: read/write; 1 = rising-edge, 0 = level.
  - 0x0C CLAIM: read only.
  - 0x10 COMPLETE: write only.
  - Unmapped reads return 0; unmapped writes are ignored. Bits at or above `INT_NUM` read 0.
- Gateway for source i:
  - Edge mode: sets pending on `int_src[i]` & ~`prev[i]`.
  - Level mode: sets pending while `int_src[i]` is high.
  - The gateway is closed for the currently claimed source until COMPLETE. Set requests from that source are dropped in the meantime.
- FSM states IDLE, ASSERT, CLAIMED:
  - IDLE: if `pending & enable` is non-zero, latch the lowest-index winner code into `cur_code` and go to ASSERT.
  - ASSERT: `peripheral_int_code = cur_code`.
    - CLAIM read: returns `cur_code`, clears that pending bit, goes to CLAIMED.
    - If the winner's enable bit is cleared first: go to IDLE, output 0, pending is kept.
    - No preemption: a higher-priority arrival waits.
  - CLAIMED: output 0. A COMPLETE write with `reg_wdata[INT_CODE_WIDTH-1:0] == cur_code` reopens the gateway and goes to IDLE. A mismatched COMPLETE is ignored.
- A CLAIM read in IDLE or CLAIMED returns 0 and causes no state change.
- Simultaneous events:
  - A claim-clear and a gateway set for the same bit in one cycle: the clear wins.
  - A pending set for other sources during a claim is kept.
  - A write to ENABLE or TRIGGER in the same cycle as an arbitration uses the old value.
- Reset values: state IDLE, `peripheral_int_code` 0, `reg_rdata` 0, pending 0, enable 0, trigger 0, `prev` 0, `cur_code` 0. A reset mid-service abandons the claim; all state is cleared.

## Timing
- Edge visible on `int_src` in cycle N: pending set at the end of N. Arbitration happens in cycle N+1. `peripheral_int_code` is valid from N+2 (2-cycle latency).
- `reg_rdata` is valid in the cycle after `reg_ren`. Its value holds until the next read. The CLAIM side effect occurs at the `reg_ren` edge.
- After a CLAIM read, `peripheral_int_code` is 0 from the next cycle.
- After COMPLETE, the next winner's code appears 2 cycles later (IDLE, then ASSERT).
- `reg_wen` and `reg_ren` are never asserted together. If they are, the write takes effect and the read returns 0.

## Structure
- Register offsets and the state encoding go in the shared include `config.v`, next to `INT_CODE_WIDTH`.
- One natural sub-module: `int_prio_enc`, a combinational lowest-index priority encoder from an `INT_NUM`-bit vector to a code.

## Test plan
- Edge source 2 with enable=0x04, trigger=0x04; one pulse on `int_src[2]` → code 3 appears two cycles later; CLAIM returns 3; PENDING = 0; code drops to 0.
- Sources 1 and 5 pulse in the same cycle, enable=0xFF → code 2 first. After CLAIM and COMPLETE(2), code 6 appears within 2 cycles.
- Level source 0 held high, enable=0x01 → CLAIM returns 1. While CLAIMED, PENDING bit 0 stays 0. After COMPLETE(1), code 1 re-asserts.
- In CLAIMED, COMPLETE(4) while `cur_code`=1 → still CLAIMED, code 0. COMPLETE(1) → returns to IDLE.
- In ASSERT with code 3, clear ENABLE bit 2 → code 0 next cycle, PENDING bit 2 still 1. Re-enable → code 3 returns.
- Assert `rst`=0 for one clock while CLAIMED → all registers 0, output 0, CLAIM read returns 0.
